process_scheduler: RTL and testbench

- Round-robin time-slice scheduler for the partitioned instruction ROM.
- The ROM has four 512-word regions: slot 0 is the OS, slots 1-3 are user programs.
- Block selects the active region, drives the base address added to the PC, counts the quantum in retired instructions, and traps back to the OS on quantum expiry or program halt.
- Sits between the OS/control unit and the instruction fetch path.

---
 rtl/process_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_process_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler over the four 512-word ROM regions.
// Optional stall watchdog trap is built when SCHED_WATCHDOG_EN is defined.
module process_scheduler #(
  parameter int ADDR_WIDTH      = 13,
  parameter int REGION_WIDTH    = 9,
  parameter int QUANTUM_WIDTH   = 8,
  parameter int DEFAULT_QUANTUM = 100,
  parameter int WATCHDOG_LIMIT  = 1024
) (
  input  logic                     Fast_Clock,
  input  logic                     Reset_n,
  input  logic                     Os_Done,
  input  logic                     Instr_Valid,
  input  logic                     Halt,
  input  logic                     Cfg_We,
  input  logic [1:0]               Cfg_Slot,
  input  logic                     Cfg_Ready,
  input  logic                     Cfg_Quantum_We,
  input  logic [QUANTUM_WIDTH-1:0] Cfg_Quantum,
  output logic [ADDR_WIDTH-1:0]    Base_Address,
  output logic [1:0]               Active_Slot,
  output logic                     Kernel_Mode,
  output logic                     Preempt,
  output logic [1:0]               Trap_Cause,
  output logic                     Idle,
  output logic [3:0]               Ready_Mask
);

  typedef enum logic [1:0] {
    KERNEL,
    PICK,
    USER,
    TRAP
  } state_t;

  state_t state, state_nx;

  logic [QUANTUM_WIDTH-1:0] quantum, quantum_nx;
  logic [QUANTUM_WIDTH-1:0] work_q, work_q_nx;
  logic [QUANTUM_WIDTH-1:0] count, count_nx;
  logic [1:0] last, last_nx;
  logic [1:0] slot_nx, cause_nx;
  logic [1:0] cand1, cand2, cand3, pick;
  logic [3:0] ready_nx;
  logic       kern_nx, pre_nx, idle_nx;
  logic       found, expire, wd_hit, trap;

  if (WATCHDOG_LIMIT < 1) begin : g_limit_check
    $error("WATCHDOG_LIMIT must be at least 1");
  end

  function automatic logic [1:0] succ(input logic [1:0] s);
    return (s == 2'd3) ? 2'd1 : s + 2'd1;
  endfunction

  assign cand1 = succ(last);
  assign cand2 = succ(cand1);
  assign cand3 = succ(cand2);

  always_comb begin
    found = 1'b1;
    pick  = cand1;
    priority case (1'b1)
      Ready_Mask[cand1]: pick = cand1;
      Ready_Mask[cand2]: pick = cand2;
      Ready_Mask[cand3]: pick = cand3;
      default:           found = 1'b0;
    endcase
  end

  assign expire = Instr_Valid &&
                  (count == work_q - 1'b1);

`ifdef SCHED_WATCHDOG_EN
  localparam int SW = $clog2(WATCHDOG_LIMIT + 1);

  logic [SW-1:0] stall, stall_nx;

  assign wd_hit = !Instr_Valid &&
                  (stall == SW'(WATCHDOG_LIMIT - 1));

  always_comb begin
    stall_nx = stall;
    if (state == PICK)
      stall_nx = '0;
    else if (state == USER)
      stall_nx = Instr_Valid ? '0 : stall + 1'b1;
  end

  always_ff @(posedge Fast_Clock or negedge Reset_n) begin
    if (!Reset_n) stall <= '0;
    else          stall <= stall_nx;
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign trap = Halt || expire || wd_hit;

  always_comb begin
    state_nx   = state;
    quantum_nx = Cfg_Quantum_We ? Cfg_Quantum : quantum;
    work_q_nx  = work_q;
    count_nx   = count;
    last_nx    = last;
    slot_nx    = Active_Slot;
    kern_nx    = Kernel_Mode;
    pre_nx     = 1'b0;
    cause_nx   = Trap_Cause;
    idle_nx    = Idle;
    ready_nx   = Ready_Mask;
    if (Cfg_We && Cfg_Slot != 2'd0)
      ready_nx[Cfg_Slot] = Cfg_Ready;

    unique case (state)
      KERNEL: if (Os_Done) state_nx = PICK;
      PICK: begin
        if (found) begin
          state_nx  = USER;
          slot_nx   = pick;
          last_nx   = pick;
          count_nx  = '0;
          work_q_nx = (quantum == '0) ? QUANTUM_WIDTH'(1) : quantum;
          kern_nx   = 1'b0;
          idle_nx   = 1'b0;
        end else begin
          state_nx  = KERNEL;
          idle_nx   = 1'b1;
        end
      end
      USER: begin
        if (Instr_Valid) count_nx = count + 1'b1;
        if (trap) begin
          state_nx = TRAP;
          pre_nx   = 1'b1;
          slot_nx  = 2'd0;
          kern_nx  = 1'b1;
        end
        // halt clears the ready bit after any same-cycle config write
        priority case (1'b1)
          Halt: begin
            cause_nx = 2'b10;
            ready_nx[Active_Slot] = 1'b0;
          end
          expire:  cause_nx = 2'b01;
          wd_hit:  cause_nx = 2'b11;
          default: ;
        endcase
      end
      TRAP: state_nx = KERNEL;
    endcase

    ready_nx[0] = 1'b0;
  end

  always_ff @(posedge Fast_Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= KERNEL;
      quantum      <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
      work_q       <= QUANTUM_WIDTH'(1);
      count        <= '0;
      last         <= 2'd3;
      Active_Slot  <= 2'd0;
      Base_Address <= '0;
      Kernel_Mode  <= 1'b1;
      Preempt      <= 1'b0;
      Trap_Cause   <= 2'b00;
      Idle         <= 1'b0;
      Ready_Mask   <= 4'b0000;
    end else begin
      state        <= state_nx;
      quantum      <= quantum_nx;
      work_q       <= work_q_nx;
      count        <= count_nx;
      last         <= last_nx;
      Active_Slot  <= slot_nx;
      Base_Address <= ADDR_WIDTH'(slot_nx) << REGION_WIDTH;
      Kernel_Mode  <= kern_nx;
      Preempt      <= pre_nx;
      Trap_Cause   <= cause_nx;
      Idle         <= idle_nx;
      Ready_Mask   <= ready_nx;
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: randomized episodes checked
// against a slot-rotation / retired-instruction model.
module tb_process_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       os_done, instr_valid, halt;
  logic       cfg_we, cfg_ready, cfg_q_we;
  logic [1:0] cfg_slot;
  logic [7:0] cfg_q;
  logic [12:0] base;
  logic [1:0] slot, cause;
  logic       kern, preempt, idle;
  logic [3:0] mask;

  always #5 clk = ~clk;

  process_scheduler dut (
    .Fast_Clock     (clk),
    .Reset_n        (rst_n),
    .Os_Done        (os_done),
    .Instr_Valid    (instr_valid),
    .Halt           (halt),
    .Cfg_We         (cfg_we),
    .Cfg_Slot       (cfg_slot),
    .Cfg_Ready      (cfg_ready),
    .Cfg_Quantum_We (cfg_q_we),
    .Cfg_Quantum    (cfg_q),
    .Base_Address   (base),
    .Active_Slot    (slot),
    .Kernel_Mode    (kern),
    .Preempt        (preempt),
    .Trap_Cause     (cause),
    .Idle           (idle),
    .Ready_Mask     (mask)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] cause;
    logic [3:0] mask;
  } trap_t;

  logic [1:0] exp_slot_q[$];
  trap_t      exp_trap_q[$];

  // reference model: ready bits, quantum register, last dispatched slot
  logic [3:0] m_mask;
  int         m_q;
  int         m_last;
  logic       prev_k;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 4'b0000;
    m_q    = 100;
    m_last = 3;
  endtask

  task automatic zero_inputs();
    os_done     = 1'b0;
    instr_valid = 1'b0;
    halt        = 1'b0;
    cfg_we      = 1'b0;
    cfg_slot    = 2'd0;
    cfg_ready   = 1'b0;
    cfg_q_we    = 1'b0;
    cfg_q       = 8'd0;
  endtask

  // kernel-time writes; stray user strobes must be ignored
  task automatic cfg_ready_wr(input logic [1:0] s, input logic v);
    @(negedge clk);
    zero_inputs();
    cfg_we      = 1'b1;
    cfg_slot    = s;
    cfg_ready   = v;
    instr_valid = 1'($urandom_range(0, 1));
    halt        = 1'($urandom_range(0, 1));
    if (s != 2'd0) m_mask[s] = v;
  endtask

  task automatic cfg_q_wr(input int q);
    @(negedge clk);
    zero_inputs();
    cfg_q_we = 1'b1;
    cfg_q    = 8'(q);
    m_q      = q;
  endtask

  task automatic check_mask();
    @(negedge clk);
    zero_inputs();
    check("ready_mask", mask, m_mask);
  endtask

  // one Os_Done dispatch and the user run that follows it
  task automatic dispatch(input bit rnd, input bit halt_last,
                          input int max_cycles);
    int pick, wq, cnt, cyc, s;
    bit iv, h;
    @(negedge clk);
    zero_inputs();
    os_done = 1'b1;
    pick = 0;
    for (int k = 1; k <= 3; k++) begin
      s = (m_last + k - 1) % 3 + 1;
      if (pick == 0 && m_mask[s]) pick = s;
    end
    @(negedge clk);
    zero_inputs();
    if (pick == 0) begin
      @(negedge clk);
      check("idle_flag", idle, 1'b1);
      check("idle_slot", slot, 2'd0);
      check("idle_kernel", kern, 1'b1);
      return;
    end
    m_last = pick;
    wq = (m_q == 0) ? 1 : m_q;
    exp_slot_q.push_back(2'(pick));
    @(negedge clk);
    cnt = 0;
    cyc = 0;
    forever begin
      zero_inputs();
      if (rnd) begin
        iv = ($urandom_range(0, 3) != 0);
        h  = ($urandom_range(0, 24) == 0);
        os_done = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 7) == 0) begin
          cfg_we    = 1'b1;
          cfg_slot  = 2'($urandom_range(0, 3));
          cfg_ready = 1'($urandom_range(0, 1));
          if (cfg_slot != 2'd0) m_mask[cfg_slot] = cfg_ready;
        end
        if ($urandom_range(0, 15) == 0) begin
          cfg_q_we = 1'b1;
          cfg_q    = 8'($urandom_range(0, 12));
          m_q      = int'(cfg_q);
        end
      end else begin
        iv = 1'b1;
        h  = halt_last && (cnt == wq - 1);
      end
      instr_valid = iv;
      halt        = h;
      if (h) begin
        m_mask[pick] = 1'b0;
        exp_trap_q.push_back('{2'b10, m_mask});
        break;
      end
      if (iv) begin
        cnt++;
        if (cnt == wq) begin
          exp_trap_q.push_back('{2'b01, m_mask});
          break;
        end
      end
      cyc++;
      if (max_cycles > 0 && cyc == max_cycles) return;
      @(negedge clk);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic random_episode();
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++)
      cfg_ready_wr(2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 3) != 0));
    if ($urandom_range(0, 2) == 0) cfg_q_wr($urandom_range(0, 10));
    check_mask();
    dispatch(1'b1, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_slot"}, slot, 2'd0);
    check({tag, "_base"}, base, 13'd0);
    check({tag, "_kernel"}, kern, 1'b1);
    check({tag, "_preempt"}, preempt, 1'b0);
    check({tag, "_cause"}, cause, 2'b00);
    check({tag, "_idle"}, idle, 1'b0);
    check({tag, "_mask"}, mask, 4'b0000);
  endtask

  // monitor: dispatches on Kernel_Mode falling, traps on Preempt
  initial begin
    trap_t t;
    logic [1:0] es;
    prev_k = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && prev_k && !kern) begin
        check("dispatch_expected", exp_slot_q.size() != 0, 1'b1);
        if (exp_slot_q.size() != 0) begin
          es = exp_slot_q.pop_front();
          check("dispatch_slot", slot, es);
          check("dispatch_base", base, 13'(es) << 9);
          check("dispatch_idle", idle, 1'b0);
        end
      end
      if (preempt === 1'b1) begin
        check("trap_expected", exp_trap_q.size() != 0, 1'b1);
        if (exp_trap_q.size() != 0) begin
          t = exp_trap_q.pop_front();
          check("trap_cause", cause, t.cause);
          check("trap_mask", mask, t.mask);
          check("trap_slot", slot, 2'd0);
          check("trap_base", base, 13'd0);
          check("trap_kernel", kern, 1'b1);
        end
      end
      prev_k = kern;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    zero_inputs();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cfg_ready_wr(2'd1, 1'b1);
    cfg_ready_wr(2'd2, 1'b1);
    cfg_ready_wr(2'd3, 1'b1);
    cfg_ready_wr(2'd0, 1'b1);
    cfg_q_wr(4);
    check_mask();
    repeat (4) dispatch(1'b0, 1'b0, 0);
    dispatch(1'b0, 1'b1, 0);
    repeat (2) dispatch(1'b0, 1'b0, 0);

    cfg_ready_wr(2'd1, 1'b0);
    cfg_ready_wr(2'd3, 1'b0);
    check_mask();
    dispatch(1'b0, 1'b0, 0);

    cfg_ready_wr(2'd2, 1'b1);
    cfg_q_wr(0);
    check_mask();
    dispatch(1'b0, 1'b0, 0);

    repeat (60) random_episode();

    cfg_ready_wr(2'd1, 1'b0);
    cfg_ready_wr(2'd3, 1'b0);
    cfg_ready_wr(2'd2, 1'b1);
    cfg_q_wr(50);
    check_mask();
    dispatch(1'b0, 1'b0, 3);
    @(negedge clk);
    zero_inputs();
    #2;
    check("user_slot", slot, 2'd2);
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) random_episode();

    repeat (4) @(negedge clk);
    check("dispatch_q_drained", exp_slot_q.size(), 0);
    check("trap_q_drained", exp_trap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
